// File: rtl/id_ex_operand_reg_if.sv
// ID/EX operand register bus: decode-side request, forwarding sources and EX-side outputs.
// The slave modport is the pipeline register itself; the master modport drives it.
interface id_ex_operand_reg_if #(
  parameter int CTRL_W = 32,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic              id_allowin;
  logic              ex_allowin;
  logic              flush;
  logic [4:0]        rs_num;
  logic [4:0]        rt_num;
  logic              rs_used;
  logic              rt_used;
  logic [1:0]        rs_select;
  logic [1:0]        rt_select;
  logic [31:0]       rf_rdata1;
  logic [31:0]       rf_rdata2;
  logic [31:0]       exe_result;
  logic [31:0]       mem_result;
  logic [31:0]       wb_result;
  logic              exe_is_load;
  logic              mem_load_pending;
  logic [31:0]       id_pc;
  logic [CTRL_W-1:0] id_ctrl;
  logic              ex_valid;
  logic [31:0]       ex_pc;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [31:0]       ex_src1;
  logic [31:0]       ex_src2;
  logic [CNT_W-1:0]  stall_cnt;

  modport slave (
    input  id_valid, ex_allowin, flush,
    input  rs_num, rt_num, rs_used, rt_used, rs_select, rt_select,
    input  rf_rdata1, rf_rdata2, exe_result, mem_result, wb_result,
    input  exe_is_load, mem_load_pending, id_pc, id_ctrl,
    output id_allowin, ex_valid, ex_pc, ex_ctrl, ex_src1, ex_src2, stall_cnt
  );

  modport master (
    output id_valid, ex_allowin, flush,
    output rs_num, rt_num, rs_used, rt_used, rs_select, rt_select,
    output rf_rdata1, rf_rdata2, exe_result, mem_result, wb_result,
    output exe_is_load, mem_load_pending, id_pc, id_ctrl,
    input  id_allowin, ex_valid, ex_pc, ex_ctrl, ex_src1, ex_src2, stall_cnt
  );
endinterface

// File: rtl/id_ex_operand_reg.sv
// ID->EX pipeline register with operand forwarding mux, load-use stall and saturating stall counter.
// Optional FWD_WB_EN: when defined, select 11 forwards wb_result; otherwise it reads the register file.
module id_ex_operand_reg #(
  parameter int CTRL_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  id_ex_operand_reg_if.slave   bus
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_WB  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Register zero always reads as zero regardless of what the hazard unit selected.
  function automatic logic [31:0] f_operand(
    input logic [4:0]  num,
    input logic [1:0]  sel,
    input logic [31:0] rf,
    input logic [31:0] exe,
    input logic [31:0] mem,
    input logic [31:0] alt
  );
    logic [31:0] v;
    v = 32'h0000_0000;
    if (num == 5'd0) begin
      v = 32'h0000_0000;
    end else begin
      case (sel)
        SEL_RF:  v = rf;
        SEL_EX:  v = exe;
        SEL_MEM: v = mem;
        SEL_WB:  v = alt;
        default: v = rf;
      endcase
    end
    return v;
  endfunction

  function automatic logic f_src_hazard(
    input logic       used,
    input logic [4:0] num,
    input logic [1:0] sel,
    input logic       ld_in_ex,
    input logic       ld_mem_pending
  );
    logic hz;
    hz = 1'b0;
    if (used && (num != 5'd0)) begin
      hz = ((sel == SEL_EX) && ld_in_ex) || ((sel == SEL_MEM) && ld_mem_pending);
    end else begin
      hz = 1'b0;
    end
    return hz;
  endfunction

  logic              r_ex_valid;
  logic [31:0]       r_ex_src1;
  logic [31:0]       r_ex_src2;
  logic [31:0]       r_ex_pc;
  logic [CTRL_W-1:0] r_ex_ctrl;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic              w_ex_valid_nxt;
  logic [31:0]       w_ex_src1_nxt;
  logic [31:0]       w_ex_src2_nxt;
  logic [31:0]       w_ex_pc_nxt;
  logic [CTRL_W-1:0] w_ex_ctrl_nxt;
  logic [CNT_W-1:0]  w_stall_cnt_nxt;

  logic [31:0]       w_wb_alt1;
  logic [31:0]       w_wb_alt2;
  logic [31:0]       w_src1;
  logic [31:0]       w_src2;
  logic              w_hz_rs;
  logic              w_hz_rt;
  logic              w_hazard;
  logic              w_ex_free;

`ifdef FWD_WB_EN
  assign w_wb_alt1 = bus.wb_result;
  assign w_wb_alt2 = bus.wb_result;
`else
  // Register file writes before it reads, so select 11 can simply take the read port.
  logic w_wb_unused;
  assign w_wb_unused = ^bus.wb_result;
  assign w_wb_alt1   = bus.rf_rdata1;
  assign w_wb_alt2   = bus.rf_rdata2;
`endif

  assign w_src1 = f_operand(bus.rs_num, bus.rs_select, bus.rf_rdata1,
                            bus.exe_result, bus.mem_result, w_wb_alt1);
  assign w_src2 = f_operand(bus.rt_num, bus.rt_select, bus.rf_rdata2,
                            bus.exe_result, bus.mem_result, w_wb_alt2);

  assign w_hz_rs  = f_src_hazard(bus.rs_used, bus.rs_num, bus.rs_select,
                                 bus.exe_is_load, bus.mem_load_pending);
  assign w_hz_rt  = f_src_hazard(bus.rt_used, bus.rt_num, bus.rt_select,
                                 bus.exe_is_load, bus.mem_load_pending);
  assign w_hazard = bus.id_valid & (w_hz_rs | w_hz_rt);

  assign w_ex_free      = ~r_ex_valid | bus.ex_allowin;
  assign bus.id_allowin = ~w_hazard & ~bus.flush & w_ex_free;

  // Next-state for the EX stage: flush beats hazard, hazard inserts a bubble, otherwise capture.
  always_comb begin
    w_ex_valid_nxt = r_ex_valid;
    w_ex_src1_nxt  = r_ex_src1;
    w_ex_src2_nxt  = r_ex_src2;
    w_ex_pc_nxt    = r_ex_pc;
    w_ex_ctrl_nxt  = r_ex_ctrl;
    if (bus.flush) begin
      w_ex_valid_nxt = 1'b0;
    end else if (w_ex_free) begin
      if (w_hazard) begin
        w_ex_valid_nxt = 1'b0;
      end else begin
        w_ex_valid_nxt = bus.id_valid;
        if (bus.id_valid) begin
          w_ex_src1_nxt = w_src1;
          w_ex_src2_nxt = w_src2;
          w_ex_pc_nxt   = bus.id_pc;
          w_ex_ctrl_nxt = bus.id_ctrl;
        end else begin
          w_ex_src1_nxt = r_ex_src1;
        end
      end
    end else begin
      w_ex_valid_nxt = r_ex_valid;
    end
  end

  // Stall counter counts every hazard cycle and sticks at all-ones.
  always_comb begin
    w_stall_cnt_nxt = r_stall_cnt;
    if (w_hazard && (r_stall_cnt != CNT_MAX)) begin
      w_stall_cnt_nxt = r_stall_cnt + CNT_ONE;
    end else begin
      w_stall_cnt_nxt = r_stall_cnt;
    end
  end

  // EX-stage state registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ex_valid  <= 1'b0;
      r_ex_src1   <= 32'h0000_0000;
      r_ex_src2   <= 32'h0000_0000;
      r_ex_pc     <= 32'h0000_0000;
      r_ex_ctrl   <= {CTRL_W{1'b0}};
      r_stall_cnt <= {CNT_W{1'b0}};
    end else begin
      r_ex_valid  <= w_ex_valid_nxt;
      r_ex_src1   <= w_ex_src1_nxt;
      r_ex_src2   <= w_ex_src2_nxt;
      r_ex_pc     <= w_ex_pc_nxt;
      r_ex_ctrl   <= w_ex_ctrl_nxt;
      r_stall_cnt <= w_stall_cnt_nxt;
    end
  end

  assign bus.ex_valid  = r_ex_valid;
  assign bus.ex_src1   = r_ex_src1;
  assign bus.ex_src2   = r_ex_src2;
  assign bus.ex_pc     = r_ex_pc;
  assign bus.ex_ctrl   = r_ex_ctrl;
  assign bus.stall_cnt = r_stall_cnt;

endmodule

// File: doc/id_ex_operand_reg.md
# id_ex_operand_reg

Pipeline register between decode (ID) and execute (EX) that consumes the 2-bit per-operand forwarding selects from the hazard detector. It picks each source operand from the register file or the EX/MEM/WB forwarding buses, stalls ID on load-use hazards the forwarding network cannot cover, and latches operands, PC and control word into EX under a valid/allowin handshake. It also keeps a saturating hazard-stall counter for performance debug.

## Interface
- CTRL_W, 32, width of decoded control word carried to EX
- CNT_W, 16, width of stall counter
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a valid instruction
- id_allowin  out  1  ID may hand over this cycle
- ex_allowin  in  1  EX can accept a new instruction
- flush  in  1  kill EX-bound instruction (branch/exception)
- rs_num, rt_num  in  5  source register numbers
- rs_used, rt_used  in  1  operand actually read by the instruction
- rs_select, rt_select  in  2  00 regfile, 01 EX, 10 MEM, 11 WB
- rf_rdata1, rf_rdata2  in  32  register file read data
- exe_result, mem_result, wb_result  in  32  forwarding buses
- exe_is_load  in  1  instruction in EX is a load
- mem_load_pending  in  1  load in MEM has not returned data this cycle
- id_pc  in  32; id_ctrl  in  CTRL_W
- ex_valid  out  1; ex_pc  out  32; ex_ctrl  out  CTRL_W
- ex_src1, ex_src2  out  32  resolved operands
- stall_cnt  out  CNT_W  hazard-stall cycles, saturating

## Operation
- Operand mux per source: num==0 → 0; else select 00 rf_rdata, 01 exe_result, 10 mem_result, 11 wb_result.
- Hazard (combinational), per source s in {rs,rt}: id_valid & s_used & s_num!=0 & ((s_select==01 & exe_is_load) | (s_select==10 & mem_load_pending)).
- id_allowin = !hazard & !flush & (!ex_valid | ex_allowin).
- Register update, only when (!ex_valid | ex_allowin) or flush:
  - flush: ex_valid←0, others hold.
  - else hazard: ex_valid←0 (bubble), data regs hold.
  - else: ex_valid←id_valid; if id_valid, capture ex_src1/2, ex_pc, ex_ctrl.
- When ex_valid & !ex_allowin & !flush: all outputs hold, id_allowin=0.
- stall_cnt increments by 1 in every cycle hazard=1, holds at all-ones (no wrap). Not cleared by flush.
- flush dominates hazard and capture in the same cycle.

## Timing
- Reset (async, resetn=0): ex_valid=0, ex_src1=ex_src2=0, ex_pc=0, ex_ctrl=0, stall_cnt=0. id_allowin follows combinationally (=1 when id_valid=0 or no hazard).
- Latency: operand/PC/ctrl presented at ID in cycle N appear on ex_* after rising edge ending N (1 cycle).
- Load in EX with dependent instruction in ID: exactly one bubble if the load leaves MEM with data the next cycle; additional bubble per cycle of mem_load_pending.
- Reset deassertion mid-stream: no instruction survives; first capture on first edge with resetn=1.
- Data regs never change while ex_valid=1 and ex_allowin=0.

## Configuration
- FWD_WB_EN defined: select 11 routes wb_result.
- FWD_WB_EN undefined: select 11 treated as 00 (rf_rdata); register file is required to write-before-read. Hazard logic unchanged.

## Test plan
- Reset mid-transfer (ex_valid=1, resetn pulsed low between edges) → ex_valid=0, ex_src1=0, stall_cnt=0 immediately, before next edge.
- rs_num=5, rs_select=01, exe_result=0x1234, exe_is_load=0, id_valid=1, ex_allowin=1 → next cycle ex_valid=1, ex_src1=0x1234; rt_num=0 → ex_src2=0.
- rs_select=01, exe_is_load=1, rs_used=1 → id_allowin=0, next cycle ex_valid=0, stall_cnt=1; then select 10, mem_load_pending=0, mem_result=0xBEEF → ex_src1=0xBEEF.
- Same hazard with rs_used=0 → no stall, capture proceeds, stall_cnt unchanged.
- ex_valid=1, ex_allowin=0 for 3 cycles while inputs change → ex_* stable, id_allowin=0; flush asserted in 2nd cycle → ex_valid=0 next edge.
- CNT_W=4, hazard held 20 cycles → stall_cnt saturates at 15; with FWD_WB_EN undefined, select 11, wb_result=0x1, rf_rdata1=0x2 → ex_src1=0x2.
